// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_core
// Description : Parametrised stopwatch. A prescaler divides clk down to
//               TICK_HZ sub-second ticks. The block counts ticks within the
//               second (subsec) and whole seconds. It also provides
//               run/stop, clear, lap capture and seconds-overflow reporting.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start_stop   in   1      single-cycle pulse, toggles running
//   clear        in   1      single-cycle pulse, zeroes counts/prescaler/lap/overflow
//   lap          in   1      single-cycle pulse, captures current time
//   running      out  1      high while counting
//   seconds      out  SEC_W  elapsed whole seconds
//   subsec       out  SUB_W  ticks within current second, 0..TICK_HZ-1
//   lap_seconds  out  SEC_W  seconds at last lap
//   lap_subsec   out  SUB_W  subsec at last lap
//   lap_valid    out  1      one-cycle pulse with the lap registers update
//   overflow     out  1      seconds overflow (sticky or pulse, see below)
// Build option:
//   STOPWATCH_SATURATE_EN  defined   : counts saturate at the maximum time,
//                                      running drops, overflow is sticky and
//                                      start_stop is ignored while it is set.
//                          undefined : seconds wraps to 0, overflow is a
//                                      one-cycle pulse, running is unchanged.
// ============================================================================
module stopwatch_core #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100,
  parameter int SEC_W   = 13,
  parameter int SUB_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  output logic             running,
  output logic [SEC_W-1:0] seconds,
  output logic [SUB_W-1:0] subsec,
  output logic [SEC_W-1:0] lap_seconds,
  output logic [SUB_W-1:0] lap_subsec,
  output logic             lap_valid,
  output logic             overflow
);

  localparam int               DIV        = CLK_HZ / TICK_HZ;
  localparam int               PRE_W      = $clog2(DIV);
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [SUB_W-1:0] C_SUB_LAST = SUB_W'(TICK_HZ - 1);
  localparam logic [SEC_W-1:0] C_SEC_MAX  = {SEC_W{1'b1}};

  logic [PRE_W-1:0] pre_q,     pre_d;
  logic             running_q, running_d;
  logic [SEC_W-1:0] seconds_q, seconds_d;
  logic [SUB_W-1:0] subsec_q,  subsec_d;
  logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
  logic [SUB_W-1:0] lap_sub_q, lap_sub_d;
  logic             lap_vld_q, lap_vld_d;
  logic             ovf_q,     ovf_d;

  logic             tick;
  logic             at_max;
  logic             sat_hit;

  // A tick is issued on the cycle the prescaler sits at its last value.
  assign tick   = running_q && (pre_q == C_PRE_LAST);
  assign at_max = (seconds_q == C_SEC_MAX) && (subsec_q == C_SUB_LAST);

  always_comb begin
    pre_d     = pre_q;
    running_d = running_q;
    seconds_d = seconds_q;
    subsec_d  = subsec_q;
    lap_sec_d = lap_sec_q;
    lap_sub_d = lap_sub_q;
    lap_vld_d = lap;
    sat_hit   = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
    ovf_d     = ovf_q;
`else
    ovf_d     = 1'b0;
`endif

    if (clear) begin
      // Clear wins over tick and start_stop; running is left alone.
      pre_d     = '0;
      seconds_d = '0;
      subsec_d  = '0;
      lap_sec_d = '0;
      lap_sub_d = '0;
      ovf_d     = 1'b0;
    end else begin
      // Prescaler only advances while running, so a pause keeps the
      // partial tick and resume finishes it.
      if (running_q) begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
      end

      if (tick) begin
`ifdef STOPWATCH_SATURATE_EN
        if (at_max) begin
          sat_hit = 1'b1;
          ovf_d   = 1'b1;
        end else
`endif
        if (subsec_q == C_SUB_LAST) begin
          subsec_d  = '0;
          seconds_d = seconds_q + SEC_W'(1);
`ifndef STOPWATCH_SATURATE_EN
          ovf_d     = at_max;
`endif
        end else begin
          subsec_d = subsec_q + SUB_W'(1);
        end
      end

`ifdef STOPWATCH_SATURATE_EN
      if (start_stop && !ovf_q) begin
        running_d = ~running_q;
      end
      // Reaching saturation stops the watch even if start_stop coincides.
      if (sat_hit) begin
        running_d = 1'b0;
      end
`else
      if (start_stop) begin
        running_d = ~running_q;
      end
`endif
    end

    // Lap samples the pre-update register values, even alongside clear.
    if (lap) begin
      lap_sec_d = seconds_q;
      lap_sub_d = subsec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      running_q <= 1'b0;
      seconds_q <= '0;
      subsec_q  <= '0;
      lap_sec_q <= '0;
      lap_sub_q <= '0;
      lap_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      running_q <= running_d;
      seconds_q <= seconds_d;
      subsec_q  <= subsec_d;
      lap_sec_q <= lap_sec_d;
      lap_sub_q <= lap_sub_d;
      lap_vld_q <= lap_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign running     = running_q;
  assign seconds     = seconds_q;
  assign subsec      = subsec_q;
  assign lap_seconds = lap_sec_q;
  assign lap_subsec  = lap_sub_q;
  assign lap_valid   = lap_vld_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_core
// Description : Self-checking bench for stopwatch_core. The reference model
//               tracks the number of running clock cycles since the last
//               clear and derives the time from it arithmetically.
//               Honours STOPWATCH_SATURATE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 5;
  localparam int SEC_W   = 3;
  localparam int SUB_W   = 3;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int C_FULL  = (1 << SEC_W) * TICK_HZ * DIV;  // cycles per wrap

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_stop = 1'b0;
  logic             clear = 1'b0;
  logic             lap = 1'b0;
  logic             running;
  logic [SEC_W-1:0] seconds;
  logic [SUB_W-1:0] subsec;
  logic [SEC_W-1:0] lap_seconds;
  logic [SUB_W-1:0] lap_subsec;
  logic             lap_valid;
  logic             overflow;

  stopwatch_core #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .SEC_W  (SEC_W),
    .SUB_W  (SUB_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .running    (running),
    .seconds    (seconds),
    .subsec     (subsec),
    .lap_seconds(lap_seconds),
    .lap_subsec (lap_subsec),
    .lap_valid  (lap_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_n;     // running cycles since clear (mod C_FULL when wrapping)
  bit m_run;
  bit m_ovf;
  int m_ls, m_lsub;
  bit m_lv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_sec();
    return (m_n / DIV) / TICK_HZ;
  endfunction

  function automatic int m_sub();
    return (m_n / DIV) % TICK_HZ;
  endfunction

  task automatic model_reset();
    m_n = 0; m_run = 0; m_ovf = 0; m_ls = 0; m_lsub = 0; m_lv = 0;
  endtask

  task automatic model_step(input bit ss, input bit clr, input bit lp);
    bit hit;
    bit ovf_old;
    hit     = 0;
    ovf_old = m_ovf;
`ifndef STOPWATCH_SATURATE_EN
    m_ovf = 0;
`endif
    if (lp) begin
      m_ls   = m_sec();
      m_lsub = m_sub();
    end else if (clr) begin
      m_ls   = 0;
      m_lsub = 0;
    end
    m_lv = lp;
    if (clr) begin
      m_n   = 0;
      m_ovf = 0;
    end else begin
      if (m_run) begin
`ifdef STOPWATCH_SATURATE_EN
        if (m_n == C_FULL - 1) begin
          // Final tick would wrap: hold at the last tick, watch stops.
          m_n   = C_FULL - DIV;
          hit   = 1;
          m_run = 0;
          m_ovf = 1;
        end else begin
          m_n = m_n + 1;
        end
`else
        m_n = m_n + 1;
        if (m_n == C_FULL) begin
          m_n   = 0;
          m_ovf = 1;
        end
`endif
      end
`ifdef STOPWATCH_SATURATE_EN
      if (ss && !hit && !ovf_old) m_run = !m_run;
`else
      if (ss) m_run = !m_run;
`endif
    end
  endtask

  task automatic compare_all(input string where);
    chk({where, ":running"},   32'(running),     32'(m_run));
    chk({where, ":seconds"},   32'(seconds),     32'(m_sec()));
    chk({where, ":subsec"},    32'(subsec),      32'(m_sub()));
    chk({where, ":lap_sec"},   32'(lap_seconds), 32'(m_ls));
    chk({where, ":lap_sub"},   32'(lap_subsec),  32'(m_lsub));
    chk({where, ":lap_valid"}, 32'(lap_valid),   32'(m_lv));
    chk({where, ":overflow"},  32'(overflow),    32'(m_ovf));
  endtask

  // Drive one cycle of inputs, clock it, update model, compare at edge+1.
  task automatic step(input bit ss, input bit clr, input bit lp, input string where);
    start_stop = ss; clear = clr; lap = lp;
    @(posedge clk);
    model_step(ss, clr, lp);
    #1;
    start_stop = 0; clear = 0; lap = 0;
    compare_all(where);
  endtask

  task automatic idle(input int n, input string where);
    for (int i = 0; i < n; i++) step(0, 0, 0, where);
  endtask

  // Asynchronous reset between edges, checked before any clock edge.
  task automatic async_reset(input string where);
    rst_n = 0;
    #1;
    model_reset();
    compare_all(where);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    #2;
    compare_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1;
    idle(2, "idle");

    // Start, one second, then 25 more cycles
    step(1, 0, 0, "start");
    idle(10, "run10");
    chk("one_sec:seconds", 32'(seconds), 32'd1);
    chk("one_sec:subsec",  32'(subsec),  32'd0);
    chk("one_sec:running", 32'(running), 32'd1);
    idle(25, "run25");
    chk("r35:seconds", 32'(seconds), 32'd3);
    chk("r35:subsec",  32'(subsec),  32'd2);

    // Pause and resume
    step(1, 0, 0, "pause");
    idle(7, "paused");
    step(1, 0, 0, "resume");
    idle(6, "resumed");

    // Lap with coincident tick at 2/3
    async_reset("rst_lap");
    step(1, 0, 0, "lap_start");
    idle(27, "lap_run");
    step(0, 0, 1, "lap_cap");
    chk("lap:lap_sec",   32'(lap_seconds), 32'd2);
    chk("lap:lap_sub",   32'(lap_subsec),  32'd3);
    chk("lap:lap_valid", 32'(lap_valid),   32'd1);
    chk("lap:live_sub",  32'(subsec),      32'd4);
    step(0, 0, 0, "lap_after");
    chk("lap:valid_drop", 32'(lap_valid), 32'd0);

    // clear + start_stop while running at 5/1
    async_reset("rst_clr");
    step(1, 0, 0, "clr_start");
    idle(52, "clr_run");
    chk("pre_clr:seconds", 32'(seconds), 32'd5);
    chk("pre_clr:subsec",  32'(subsec),  32'd1);
    step(1, 1, 0, "clr_ss");
    chk("clr:seconds", 32'(seconds), 32'd0);
    chk("clr:running", 32'(running), 32'd1);

    // 80 running cycles from zero
    async_reset("rst_ovf");
    step(1, 0, 0, "ovf_start");
    idle(80, "ovf_run");
`ifdef STOPWATCH_SATURATE_EN
    chk("sat:seconds",  32'(seconds),  32'd7);
    chk("sat:subsec",   32'(subsec),   32'd4);
    chk("sat:running",  32'(running),  32'd0);
    chk("sat:overflow", 32'(overflow), 32'd1);
    step(1, 0, 0, "sat_ss");
    chk("sat:ss_ignored", 32'(running), 32'd0);
    chk("sat:ovf_held",   32'(overflow), 32'd1);
`else
    chk("wrap:seconds",  32'(seconds),  32'd0);
    chk("wrap:subsec",   32'(subsec),   32'd0);
    chk("wrap:running",  32'(running),  32'd1);
    chk("wrap:overflow", 32'(overflow), 32'd1);
    step(0, 0, 0, "wrap_after");
    chk("wrap:ovf_pulse", 32'(overflow), 32'd0);
`endif

    // Randomized traffic with a mid-run asynchronous reset
    step(0, 1, 0, "rnd_clr");
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset("rnd_rst");
      step(($urandom % 8) == 0, ($urandom % 60) == 0, ($urandom % 10) == 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
